ram_buffer_pool: RTL and testbench
==================================

// Module: ram_buffer_pool
// PURPOSE
//  Parametrised pool of ENT_NUM RAM-buffer entries between the AXI read path and the MXU.
//  Each entry holds one DATA_W line plus its tag address, a reference count and a byte window.
//  Lines are streamed to the MXU in allocation order, one byte per beat, forward or reverse.
//  Lookup hits against the tags let later AXI reads reuse held lines.
// PARAMETERS
//  ENT_NUM  4    number of entries (2..16)
//  DATA_W   128  line width in bits, a multiple of 8; NB = DATA_W/8 byte lanes
//  ADDR_W   8    tag address width
//  CNT_W    3    reference counter width; saturates at 2**CNT_W-1
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            synchronous active-low reset
//  alloc_vld       in   1            allocation request
//  alloc_rdy       out  1            a free entry exists
//  alloc_addr      in   ADDR_W       tag of the line
//  alloc_data      in   DATA_W       line data
//  alloc_start     in   clog2(NB)    first byte index to stream
//  alloc_end       in   clog2(NB)    last byte index to stream
//  rd_addr         in   ADDR_W       lookup address
//  rd_hit          out  1            some held entry's tag == rd_addr
//  rd_hit_idx      out  clog2(ENT)   lowest hitting entry index (0 when no hit)
//  cnt_inc         in   ENT_NUM      per-entry reference increment
//  cnt_dec         in   ENT_NUM      per-entry reference decrement
//  out_vld         out  1            stream beat valid
//  out_rdy         in   1            MXU accepts beat
//  out_data        out  DATA_W       one byte in lane k, other lanes zero
//  out_byte_msk    out  NB           one-hot lane k
//  out_ent_idx     out  clog2(ENT)   entry being streamed
//  out_last        out  1            final beat of this entry
//  err_flag        out  3            sticky errors {alloc_full, inc_ovf, dec_unf}
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all entries FREE, cnt=0, order queue empty,
//    out_vld=0, out_last=0, err_flag=0. Any stream in progress is abandoned. Data and tags are not reset.
//  - Entry is FREE when cnt==0 and it is neither queued nor streaming.
//  - alloc_rdy = any FREE entry, decoded from registered state only.
//    An entry freed at edge T is usable from T+1.
//  - Allocation on alloc_vld&alloc_rdy takes the lowest-index FREE entry.
//    It loads data, tag, start and end, sets cnt=1 and pushes the index onto the order queue (depth ENT_NUM).
//  - Lookup is combinational over registered state. Valid = not FREE.
//    Same-cycle allocations are not visible until the next cycle. Duplicate tags are permitted.
//  - Ref count per entry:
//    - alloc: set cnt=1; same-cycle inc/dec on that entry is ignored.
//    - inc & dec together: hold.
//    - inc at max: hold, and set inc_ovf.
//    - dec at 0: hold, and set dec_unf.
//  - Streamer FSM IDLE/STREAM:
//    - IDLE: pops the queue head when the queue is non-empty. Goes to STREAM; out_vld=1 the next cycle.
//      Minimum latency: accepted alloc at edge T, first beat valid after edge T+1.
//    - STREAM: beat k (k=0..) outputs byte cur, placed in lane k.
//      cur starts at start and moves +1 if end>=start, else -1.
//    - Beats = |end-start|+1 (1..NB). out_last is asserted with byte index end.
//    - Advances only on out_vld&out_rdy. out_* hold stable while out_vld&!out_rdy.
//    - On the last handshake: pop the next entry back-to-back if the queue is non-empty, else go to IDLE.
//  - Streaming completion does not change cnt. An entry becomes FREE only when the stream is done and cnt==0.
//  - Simultaneous events:
//    - Alloc and pop in the same cycle with a full queue are legal (push and pop).
//    - Dec to 0 in the last-beat cycle frees the entry at that edge.
//  - alloc_vld while !alloc_rdy is dropped. It sets alloc_full when errors are enabled.
// CONFIGURATION
//  - RAM_BUFFER_ERR_EN defined: err_flag bits are sticky and cleared only by reset.
//  - RAM_BUFFER_ERR_EN undefined: err_flag is tied to 3'b000 and no error logic is built.
// TESTING
//  1. Alloc addr=8'h10, start=0, end=3, data bytes 0..15 = 8'h00..8'h0F, out_rdy=1.
//     -> 4 beats, lanes 0..3 carry 00,01,02,03; out_last on beat 3; then out_vld=0.
//  2. Alloc start=5, end=2.
//     -> beats carry bytes 05,04,03,02 in lanes 0..3; masks 0001,0002,0004,0008.
//  3. Fill 4 entries (cnt stays 1 after streaming).
//     -> alloc_rdy=0; 5th alloc dropped; err_flag[2]=1 with RAM_BUFFER_ERR_EN.
//     Then cnt_dec[2]=1 -> alloc_rdy=1 next cycle; the next alloc takes entry 2.
//  4. Lookup rd_addr=8'h10 while entries 1 and 3 hold tag 8'h10 -> rd_hit=1, rd_hit_idx=1.
//     Decrement entry 1 to 0 -> rd_hit_idx=3.
//  5. Backpressure: out_rdy=0 for 3 cycles mid-stream -> out_data and msk held.
//     Two queued entries stream back-to-back with no idle cycle.
//  6. Hazards and reset:
//     - cnt_inc&cnt_dec on entry 0 -> cnt unchanged.
//     - cnt_dec at 0 -> err_flag[0]=1 (0 without the macro).
//     - rst_n=0 mid-stream -> out_vld=0 and all entries FREE the next cycle.

Source files
------------

// File: rtl/ram_buffer_pool_if.sv
// Signal bundle for ram_buffer_pool: allocation, tag lookup, reference counts,
// the byte stream towards the MXU and the sticky error flags.
interface ram_buffer_pool_if #(
  parameter int ENT_NUM = 4,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 8
);
  localparam int NB   = DATA_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int EI_W = $clog2(ENT_NUM);

  logic              alloc_vld;
  logic              alloc_rdy;
  logic [ADDR_W-1:0] alloc_addr;
  logic [DATA_W-1:0] alloc_data;
  logic [BI_W-1:0]   alloc_start;
  logic [BI_W-1:0]   alloc_end;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [EI_W-1:0]   rd_hit_idx;

  logic [ENT_NUM-1:0] cnt_inc;
  logic [ENT_NUM-1:0] cnt_dec;

  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_data;
  logic [NB-1:0]     out_byte_msk;
  logic [EI_W-1:0]   out_ent_idx;
  logic              out_last;

  logic [2:0]        err_flag;

  modport master (
    output alloc_vld, alloc_addr, alloc_data, alloc_start, alloc_end,
    output rd_addr, cnt_inc, cnt_dec, out_rdy,
    input  alloc_rdy, rd_hit, rd_hit_idx,
    input  out_vld, out_data, out_byte_msk, out_ent_idx, out_last, err_flag
  );

  modport slave (
    input  alloc_vld, alloc_addr, alloc_data, alloc_start, alloc_end,
    input  rd_addr, cnt_inc, cnt_dec, out_rdy,
    output alloc_rdy, rd_hit, rd_hit_idx,
    output out_vld, out_data, out_byte_msk, out_ent_idx, out_last, err_flag
  );
endinterface

// File: rtl/ram_buffer_pool.sv
// Pool of RAM-buffer entries streamed byte-by-byte to the MXU in allocation order.
// Define RAM_BUFFER_ERR_EN to build the sticky err_flag logic; otherwise err_flag is 0.
module ram_buffer_pool #(
  parameter int ENT_NUM = 4,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 3
) (
  input logic              clk,
  input logic              rst_n,
  ram_buffer_pool_if.slave bus
);
  localparam int NB   = DATA_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int EI_W = $clog2(ENT_NUM);
  localparam int QC_W = $clog2(ENT_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, STREAM} state_e;

  logic [DATA_W-1:0]  data_q  [ENT_NUM];
  logic [ADDR_W-1:0]  tag_q   [ENT_NUM];
  logic [BI_W-1:0]    start_q [ENT_NUM];
  logic [BI_W-1:0]    end_q   [ENT_NUM];
  logic [CNT_W-1:0]   cnt_q   [ENT_NUM];
  logic [CNT_W-1:0]   cnt_d   [ENT_NUM];
  logic [ENT_NUM-1:0] queued_q;

  logic [EI_W-1:0]    q_mem [ENT_NUM];
  logic [EI_W-1:0]    q_rd_ptr, q_wr_ptr;
  logic [QC_W-1:0]    q_cnt;

  state_e             state_q, state_d;
  logic [EI_W-1:0]    cur_ent_q, cur_ent_d;
  logic [BI_W-1:0]    cur_byte_q, cur_byte_d;
  logic [BI_W-1:0]    beat_q, beat_d;
  logic               pop;

  logic [ENT_NUM-1:0] free;
  logic [EI_W-1:0]    alloc_idx;
  logic               alloc_rdy, alloc_fire;
  logic               hit;
  logic [EI_W-1:0]    hit_idx;
  logic [BI_W-1:0]    cur_start, cur_end;
  logic [7:0]         cur_byte_val;
  logic               stream_vld, stream_last;

  function automatic logic [EI_W-1:0] ptr_inc(input logic [EI_W-1:0] p);
    return (p == EI_W'(ENT_NUM - 1)) ? '0 : p + EI_W'(1);
  endfunction

  // An entry is busy while it holds references, waits in the queue or is on the wire.
  always_comb begin
    for (int i = 0; i < ENT_NUM; i++)
      free[i] = (cnt_q[i] == '0) && !queued_q[i] &&
                !(state_q == STREAM && cur_ent_q == EI_W'(i));
  end

  always_comb begin
    alloc_idx = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      if (free[i]) alloc_idx = EI_W'(i);
      if (!free[i] && tag_q[i] == bus.rd_addr) begin
        hit     = 1'b1;
        hit_idx = EI_W'(i);
      end
    end
  end

  assign alloc_rdy      = |free;
  assign alloc_fire     = bus.alloc_vld && alloc_rdy;
  assign bus.alloc_rdy  = alloc_rdy;
  assign bus.rd_hit     = hit;
  assign bus.rd_hit_idx = hit_idx;

  assign cur_start    = start_q[cur_ent_q];
  assign cur_end      = end_q[cur_ent_q];
  assign cur_byte_val = data_q[cur_ent_q][{cur_byte_q, 3'b000} +: 8];
  assign stream_vld   = (state_q == STREAM);
  assign stream_last  = stream_vld && (cur_byte_q == cur_end);

  assign bus.out_vld      = stream_vld;
  assign bus.out_last     = stream_last;
  assign bus.out_ent_idx  = cur_ent_q;
  assign bus.out_byte_msk = stream_vld ? ({{(NB-1){1'b0}}, 1'b1} << beat_q) : '0;
  assign bus.out_data     = stream_vld ?
                            ({{(DATA_W-8){1'b0}}, cur_byte_val} << {beat_q, 3'b000}) : '0;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    cur_ent_d  = cur_ent_q;
    cur_byte_d = cur_byte_q;
    beat_d     = beat_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (q_cnt != '0) begin
          pop     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.out_rdy) begin
          if (stream_last) begin
            if (q_cnt != '0) pop = 1'b1;
            else             state_d = IDLE;
          end else begin
            beat_d     = beat_q + BI_W'(1);
            cur_byte_d = (cur_end >= cur_start) ? cur_byte_q + BI_W'(1)
                                                : cur_byte_q - BI_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      cur_ent_d  = q_mem[q_rd_ptr];
      cur_byte_d = start_q[q_mem[q_rd_ptr]];
      beat_d     = '0;
    end
  end

  // Allocation overrides any same-cycle inc/dec on the entry it claims.
  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (alloc_fire && alloc_idx == EI_W'(i))
        cnt_d[i] = CNT_W'(1);
      else if (bus.cnt_inc[i] && !bus.cnt_dec[i] && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (bus.cnt_dec[i] && !bus.cnt_inc[i] && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_ent_q  <= '0;
      cur_byte_q <= '0;
      beat_q     <= '0;
      q_rd_ptr   <= '0;
      q_wr_ptr   <= '0;
      q_cnt      <= '0;
      queued_q   <= '0;
      for (int i = 0; i < ENT_NUM; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cur_ent_q  <= cur_ent_d;
      cur_byte_q <= cur_byte_d;
      beat_q     <= beat_d;
      q_cnt      <= q_cnt + QC_W'(alloc_fire) - QC_W'(pop);
      for (int i = 0; i < ENT_NUM; i++) cnt_q[i] <= cnt_d[i];
      if (pop) begin
        q_rd_ptr            <= ptr_inc(q_rd_ptr);
        queued_q[cur_ent_d] <= 1'b0;
      end
      if (alloc_fire) begin
        q_wr_ptr            <= ptr_inc(q_wr_ptr);
        queued_q[alloc_idx] <= 1'b1;
      end
    end
  end

  // NOTE: line storage and the order ring are never read before being written, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      data_q[alloc_idx]  <= bus.alloc_data;
      tag_q[alloc_idx]   <= bus.alloc_addr;
      start_q[alloc_idx] <= bus.alloc_start;
      end_q[alloc_idx]   <= bus.alloc_end;
      q_mem[q_wr_ptr]    <= alloc_idx;
    end
  end

`ifdef RAM_BUFFER_ERR_EN
  logic [2:0] err_q;
  logic       inc_ovf, dec_unf;

  always_comb begin
    inc_ovf = 1'b0;
    dec_unf = 1'b0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!(alloc_fire && alloc_idx == EI_W'(i)) && (bus.cnt_inc[i] != bus.cnt_dec[i])) begin
        if (bus.cnt_inc[i] && cnt_q[i] == CNT_MAX) inc_ovf = 1'b1;
        if (bus.cnt_dec[i] && cnt_q[i] == '0)      dec_unf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_q | {bus.alloc_vld && !alloc_rdy, inc_ovf, dec_unf};
  end

  assign bus.err_flag = err_q;
`else
  assign bus.err_flag = 3'b000;
`endif

endmodule

// File: tb/tb_ram_buffer_pool.sv
// Directed bench for ram_buffer_pool: a queue/array model of the pool is compared
// against the DUT every cycle, plus hand-computed literal checks per scenario.
module tb_ram_buffer_pool;
  localparam int ENT_NUM = 4;
  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = 3;
  localparam int NB      = DATA_W / 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef RAM_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_buffer_pool_if #(.ENT_NUM(ENT_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_buffer_pool #(.ENT_NUM(ENT_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- pool model ----------------
  int                m_cnt    [ENT_NUM];
  bit                m_queued [ENT_NUM];
  logic [ADDR_W-1:0] m_tag    [ENT_NUM];
  logic [DATA_W-1:0] m_data   [ENT_NUM];
  int                m_start  [ENT_NUM];
  int                m_end    [ENT_NUM];
  int                m_q[$];
  bit                m_active;
  int                m_ent, m_k;
  logic [2:0]        m_err;
  bit                m_started = 1'b0;

  function automatic bit m_free(input int i);
    return m_cnt[i] == 0 && !m_queued[i] && !(m_active && m_ent == i);
  endfunction

  function automatic int m_beats(input int e);
    return ((m_end[e] >= m_start[e]) ? m_end[e] - m_start[e] : m_start[e] - m_end[e]) + 1;
  endfunction

  function automatic int m_byte_idx(input int e, input int k);
    return (m_end[e] >= m_start[e]) ? m_start[e] + k : m_start[e] - k;
  endfunction

  always @(posedge clk) begin
    int  aidx;
    bit  fire;
    if (!rst_n) begin
      for (int i = 0; i < ENT_NUM; i++) begin
        m_cnt[i]    = 0;
        m_queued[i] = 1'b0;
      end
      m_q.delete();
      m_active  = 1'b0;
      m_ent     = 0;
      m_k       = 0;
      m_err     = 3'b000;
      m_started = 1'b1;
    end else begin
      aidx = -1;
      for (int i = ENT_NUM - 1; i >= 0; i--) if (m_free(i)) aidx = i;
      fire = bus.alloc_vld && (aidx >= 0);
      if (bus.alloc_vld && aidx < 0) m_err[2] = 1'b1;
      for (int i = 0; i < ENT_NUM; i++) begin
        if (fire && i == aidx) continue;
        if (bus.cnt_inc[i] && bus.cnt_dec[i]) continue;
        if (bus.cnt_inc[i]) begin
          if (m_cnt[i] == CNT_MAX) m_err[1] = 1'b1;
          else                     m_cnt[i]++;
        end else if (bus.cnt_dec[i]) begin
          if (m_cnt[i] == 0) m_err[0] = 1'b1;
          else               m_cnt[i]--;
        end
      end
      if (m_active) begin
        if (bus.out_rdy) begin
          if (m_k == m_beats(m_ent) - 1) begin
            if (m_q.size() > 0) begin
              m_ent = m_q.pop_front();
              m_queued[m_ent] = 1'b0;
              m_k = 0;
            end else begin
              m_active = 1'b0;
            end
          end else begin
            m_k++;
          end
        end
      end else if (m_q.size() > 0) begin
        m_ent = m_q.pop_front();
        m_queued[m_ent] = 1'b0;
        m_k = 0;
        m_active = 1'b1;
      end
      if (fire) begin
        m_cnt[aidx]    = 1;
        m_queued[aidx] = 1'b1;
        m_tag[aidx]    = bus.alloc_addr;
        m_data[aidx]   = bus.alloc_data;
        m_start[aidx]  = int'(bus.alloc_start);
        m_end[aidx]    = int'(bus.alloc_end);
        m_q.push_back(aidx);
      end
    end
  end

  always @(negedge clk) begin
    bit   any_free, exp_hit;
    int   exp_hit_idx, bi;
    logic [DATA_W-1:0] exp_data;
    if (m_started) begin
      any_free    = 1'b0;
      exp_hit     = 1'b0;
      exp_hit_idx = 0;
      for (int i = ENT_NUM - 1; i >= 0; i--) begin
        if (m_free(i)) any_free = 1'b1;
        else if (m_tag[i] == bus.rd_addr) begin
          exp_hit     = 1'b1;
          exp_hit_idx = i;
        end
      end
      check("m_alloc_rdy", bus.alloc_rdy, any_free);
      check("m_rd_hit", bus.rd_hit, exp_hit);
      check("m_rd_hit_idx", bus.rd_hit_idx, exp_hit_idx);
      check("m_out_vld", bus.out_vld, m_active);
      if (m_active) begin
        bi       = m_byte_idx(m_ent, m_k);
        exp_data = DATA_W'(m_data[m_ent][8*bi +: 8]) << (8 * m_k);
        check("m_out_data", bus.out_data, exp_data);
        check("m_out_msk", bus.out_byte_msk, NB'(1) << m_k);
        check("m_out_ent", bus.out_ent_idx, m_ent);
        check("m_out_last", bus.out_last, m_k == m_beats(m_ent) - 1);
      end
      check("m_err_flag", bus.err_flag, ERR_EN ? m_err : 3'b000);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DATA_W-1:0] ramp(input logic [7:0] base);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < NB; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [7:0] a, input logic [7:0] base, input int s, input int e);
    bus.alloc_vld   = 1'b1;
    bus.alloc_addr  = a;
    bus.alloc_data  = ramp(base);
    bus.alloc_start = 4'(s);
    bus.alloc_end   = 4'(e);
    tick();
    bus.alloc_vld   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    tick();
    while (bus.out_vld && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", n < 200, 1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] held_data;
    logic [NB-1:0]     held_msk;
    int n;
    bus.alloc_vld   = 1'b0;
    bus.alloc_addr  = '0;
    bus.alloc_data  = '0;
    bus.alloc_start = '0;
    bus.alloc_end   = '0;
    bus.rd_addr     = '0;
    bus.cnt_inc     = '0;
    bus.cnt_dec     = '0;
    bus.out_rdy     = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_alloc_rdy", bus.alloc_rdy, 1'b1);
    check("rst_out_vld", bus.out_vld, 1'b0);
    check("rst_err", bus.err_flag, 3'b000);
    tick();

    // forward stream of bytes 0..3
    alloc(8'h10, 8'h00, 0, 3);
    @(negedge clk); check("t1_lat_vld", bus.out_vld, 1'b0);
    @(negedge clk); check("t1_b0", bus.out_data, 128'h00); check("t1_m0", bus.out_byte_msk, 16'h0001);
    check("t1_ent", bus.out_ent_idx, 2'd0);
    @(negedge clk); check("t1_b1", bus.out_data, 128'h0100);     check("t1_m1", bus.out_byte_msk, 16'h0002);
    @(negedge clk); check("t1_b2", bus.out_data, 128'h020000);   check("t1_m2", bus.out_byte_msk, 16'h0004);
    @(negedge clk); check("t1_b3", bus.out_data, 128'h03000000); check("t1_last", bus.out_last, 1'b1);
    @(negedge clk); check("t1_done", bus.out_vld, 1'b0);
    tick();

    // reverse stream of bytes 5..2 into entry 1
    alloc(8'h10, 8'h00, 5, 2);
    @(negedge clk);
    @(negedge clk); check("t2_b0", bus.out_data, 128'h05);       check("t2_m0", bus.out_byte_msk, 16'h0001);
    check("t2_ent", bus.out_ent_idx, 2'd1); check("t2_nlast", bus.out_last, 1'b0);
    @(negedge clk); check("t2_b1", bus.out_data, 128'h0400);     check("t2_m1", bus.out_byte_msk, 16'h0002);
    @(negedge clk); check("t2_b2", bus.out_data, 128'h030000);   check("t2_m2", bus.out_byte_msk, 16'h0004);
    @(negedge clk); check("t2_b3", bus.out_data, 128'h02000000); check("t2_m3", bus.out_byte_msk, 16'h0008);
    check("t2_last", bus.out_last, 1'b1);
    tick();

    // fill the pool, drop an alloc, free entry 2 and reuse it
    alloc(8'h30, 8'h40, 0, 15);
    alloc(8'h10, 8'h80, 15, 0);
    wait_idle();
    check("t3_full", bus.alloc_rdy, 1'b0);
    alloc(8'h77, 8'h00, 0, 0);
    check("t3_drop_rdy", bus.alloc_rdy, 1'b0);
    check("t3_err_full", bus.err_flag[2], ERR_EN);
    bus.cnt_dec = 4'b0100;
    tick();
    bus.cnt_dec = '0;
    check("t3_rdy_again", bus.alloc_rdy, 1'b1);
    alloc(8'h40, 8'h20, 0, 1);
    tick();
    check("t3_reuse_ent", bus.out_ent_idx, 2'd2);
    wait_idle();

    // tag lookup with duplicate tags
    bus.rd_addr = 8'h10;
    #1;
    check("t4_hit", bus.rd_hit, 1'b1);
    check("t4_idx0", bus.rd_hit_idx, 2'd0);
    bus.cnt_dec = 4'b0001;
    tick();
    bus.cnt_dec = '0;
    check("t4_idx1", bus.rd_hit_idx, 2'd1);
    bus.cnt_dec = 4'b0010;
    tick();
    bus.cnt_dec = '0;
    check("t4_idx3", bus.rd_hit_idx, 2'd3);
    bus.rd_addr = 8'h55;
    #1;
    check("t4_miss", bus.rd_hit, 1'b0);
    check("t4_miss_idx", bus.rd_hit_idx, 2'd0);

    // backpressure and back-to-back streams
    alloc(8'h50, 8'h60, 0, 7);
    alloc(8'h60, 8'hA0, 3, 0);
    tick();
    tick();
    bus.out_rdy = 1'b0;
    held_data = bus.out_data;
    held_msk  = bus.out_byte_msk;
    check("t5_pre_data", held_data, 128'h620000);
    tick();
    tick();
    tick();
    check("t5_hold_data", bus.out_data, held_data);
    check("t5_hold_msk", bus.out_byte_msk, held_msk);
    check("t5_hold_vld", bus.out_vld, 1'b1);
    bus.out_rdy = 1'b1;
    n = 0;
    while (!(bus.out_last && bus.out_ent_idx == 2'd0) && n < 50) begin
      tick();
      n++;
    end
    check("t5_last_timeout", n < 50, 1'b1);
    tick();
    check("t5_b2b_vld", bus.out_vld, 1'b1);
    check("t5_b2b_ent", bus.out_ent_idx, 2'd1);
    check("t5_b2b_data", bus.out_data, 128'hA3);
    wait_idle();

    // counter hazards
    bus.cnt_inc = 4'b0001;
    bus.cnt_dec = 4'b0001;
    tick();
    bus.cnt_inc = '0;
    check("t6_incdec_rdy", bus.alloc_rdy, 1'b0);
    tick();
    bus.cnt_dec = '0;
    check("t6_dec_free", bus.alloc_rdy, 1'b1);
    check("t6_no_unf", bus.err_flag[0], 1'b0);
    bus.cnt_dec = 4'b0001;
    tick();
    bus.cnt_dec = '0;
    check("t6_unf", bus.err_flag[0], ERR_EN);
    bus.cnt_inc = 4'b0010;
    repeat (CNT_MAX - 1) tick();
    check("t6_no_ovf", bus.err_flag[1], 1'b0);
    tick();
    bus.cnt_inc = '0;
    check("t6_ovf", bus.err_flag[1], ERR_EN);

    // reset mid-stream
    alloc(8'h99, 8'h00, 0, 15);
    tick();
    tick();
    check("t6_mid_vld", bus.out_vld, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_vld", bus.out_vld, 1'b0);
    check("t6_rst_rdy", bus.alloc_rdy, 1'b1);
    check("t6_rst_err", bus.err_flag, 3'b000);
    alloc(8'h11, 8'hC0, 2, 2);
    tick();
    check("t6_single", bus.out_data, 128'hC2);
    check("t6_single_last", bus.out_last, 1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
